oam_dma_controller: RTL and testbench
=====================================

Name: oam_dma_controller

Overview:
- Game Boy OAM DMA engine: CPU write of XX to DMA register (FF46) copies XX00–XX9F into OAM FE00–FE9F.
- Slave on the IO register bus; master on the memory router's DMA read port and DMA write port.
- Asserts O_DMA_ACTIVE for the duration so CPU-side logic can restrict the CPU to HRAM.

Parameters:
- DMA_REG_ADDR, 16'hFF46, IO address of the DMA source register.
- OAM_BASE, 16'hFE00, destination base address.
- XFER_LEN, 160, bytes per transfer (8-bit counter; must be ≤ 255).
- START_DELAY, 1, idle cycles between the register write and the first read.

Ports:
- I_CLK  in  1  system clock; all state changes on the rising edge.
- I_RESET  in  1  asynchronous reset, active-low (asserted at 0).
- I_IOREG_ADDR  in  16  IO bus address.
- IO_IOREG_DATA  inout  8  IO bus data; driven only during a read hit on DMA_REG_ADDR, else high-Z.
- I_IOREG_WE_L  in  1  IO bus write strobe, active-low.
- I_IOREG_RE_L  in  1  IO bus read strobe, active-low.
- O_RDMA_ADDR  out  16  source address to the router's DMA read port.
- I_RDMA_DATA  in  8  read data; combinationally valid in the same cycle O_RDMA_RE_L is low.
- O_RDMA_RE_L  out  1  read strobe, active-low.
- O_WDMA_ADDR  out  16  OAM destination address.
- O_WDMA_DATA  out  8  write data.
- O_WDMA_WE_L  out  1  write strobe, active-low.
- O_DMA_ACTIVE  out  1  high from the cycle after the trigger write until the last OAM write completes.

Behaviour:
- Reset values:
  - src_hi = 8'h00.
  - O_RDMA_RE_L = 1, O_WDMA_WE_L = 1.
  - O_RDMA_ADDR = 0, O_WDMA_ADDR = 0, O_WDMA_DATA = 0.
  - O_DMA_ACTIVE = 0; state = IDLE.
  - Reset mid-transfer aborts immediately; no further strobes are issued.
- Register access:
  - Trigger: I_IOREG_WE_L == 0 and I_IOREG_ADDR == DMA_REG_ADDR. Latch src_hi = data at that edge.
  - Read hit: drive IO_IOREG_DATA = src_hi in the same cycle (combinational).
  - Effective source high byte: src_hi if src_hi < 8'hE0, else src_hi − 8'h20 (echo-RAM mirror).
- States:
  - IDLE: strobes high, ACTIVE = 0. Trigger → START; load delay count = START_DELAY.
  - START: ACTIVE = 1, strobes high. Decrement delay; at 0 → XFER with idx = 0.
  - XFER: ACTIVE = 1; pipelined read and write (below).
  - DRAIN: ACTIVE = 1. WE_L = 0 writes the final byte (idx XFER_LEN−1). Next cycle → IDLE with ACTIVE = 0.
- XFER pipeline, cycle k (0 ≤ k < XFER_LEN):
  - RE_L = 0, O_RDMA_ADDR = {src_eff, k}.
  - I_RDMA_DATA latched into a holding byte at the edge.
  - For k ≥ 1: WE_L = 0, O_WDMA_ADDR = OAM_BASE + (k−1), O_WDMA_DATA = the byte latched in cycle k−1.
  - After cycle XFER_LEN−1 → DRAIN.
- Timing:
  - Outputs are registered state plus combinational decode of state and counters.
  - Total ACTIVE cycles = START_DELAY + XFER_LEN + 1 (162 by default).
- Retrigger while ACTIVE:
  - New src_hi latched; the pending write is discarded; go to START; idx restarts at 0.
  - Bytes already written to OAM are not rolled back.
- Address width: read low byte = idx[7:0]. Write address is a 16-bit add; no wrap for XFER_LEN ≤ 160.
- Simultaneous trigger and DRAIN cycle: the trigger wins; the final write is suppressed; go to START.
- Reads of FF46 during a transfer return src_hi and do not disturb the transfer.

Decomposition:
- Add to memdef.vh: DMA register address (`DMA`, FF46), OAM_LO/OAM_HI (already present), `OAM_DMA_LEN` = 160, and state encodings `DMA_IDLE`, `DMA_START`, `DMA_XFER`, `DMA_DRAIN`.
- One natural sub-module: dma_byte_counter, an 8-bit up-counter with load, clear and terminal-count flag (tc when idx == XFER_LEN−1).

Test Plan:
- Reset: hold I_RESET = 0 for 3 cycles, release → all strobes high, ACTIVE = 0, FF46 reads 8'h00.
- Write 8'hC1 to FF46:
  - ACTIVE rises the next edge.
  - First read is addr C100 after 1 START cycle.
  - Final write is addr FE9F with byte from C19F.
  - ACTIVE stays high exactly 162 cycles; memory model holds OAM[i] = WRAM[C100+i] for all 160 bytes.
- Write 8'hE3 → reads sourced from C300–C39F (mirror); FF46 reads back 8'hE3.
- Retrigger with 8'hD0 at XFER byte 50:
  - Next cycle has no strobes (START).
  - Then reads D000 onward; OAM ends with D000–D09F data.
  - 162 cycles counted from the retrigger.
- Assert reset at XFER byte 80 → strobes go high asynchronously, no further writes; OAM[80..159] unchanged.
- Pipeline check: at every XFER cycle k ≥ 1, O_WDMA_DATA equals I_RDMA_DATA of cycle k−1, and RE_L and WE_L are both low in the same cycle.

Source files
------------

// File: rtl/oam_dma_controller_pkg.sv
// Shared constants, state encoding and the echo-RAM source mapping for the OAM DMA engine.
package oam_dma_controller_pkg;

  localparam logic [15:0] DmaRegAddr = 16'hFF46;
  localparam logic [15:0] OamBase    = 16'hFE00;
  localparam int unsigned XferLen    = 160;
  localparam int unsigned StartDelay = 1;

  typedef enum logic [1:0] {StIdle, StStart, StXfer, StDrain} dma_state_e;

  // E0-FF pages mirror C0-DF (echo RAM), so the DMA reads the underlying WRAM.
  function automatic logic [7:0] src_eff(input logic [7:0] src_hi);
    return (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
  endfunction

endpackage

// File: rtl/oam_dma_controller_if.sv
// IO register strobes plus the router DMA read/write ports seen by the OAM DMA engine.
interface oam_dma_controller_if;
  logic [15:0] ioreg_addr;
  logic        ioreg_we_l;
  logic        ioreg_re_l;
  logic [15:0] rdma_addr;
  logic [7:0]  rdma_data;
  logic        rdma_re_l;
  logic [15:0] wdma_addr;
  logic [7:0]  wdma_data;
  logic        wdma_we_l;
  logic        dma_active;

  modport master (
    input  ioreg_addr, ioreg_we_l, ioreg_re_l, rdma_data,
    output rdma_addr, rdma_re_l, wdma_addr, wdma_data, wdma_we_l, dma_active
  );

  modport slave (
    output ioreg_addr, ioreg_we_l, ioreg_re_l, rdma_data,
    input  rdma_addr, rdma_re_l, wdma_addr, wdma_data, wdma_we_l, dma_active
  );
endinterface

// File: rtl/oam_dma_controller_byte_counter.sv
// 8-bit transfer index with synchronous clear and a terminal-count flag at the last byte.
module oam_dma_controller_byte_counter #(
  parameter int unsigned Len = 160
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] idx_o,
  output logic       tc_o
);

  logic [7:0] idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= 8'h00;
    end else if (clr_i) begin
      idx_q <= 8'h00;
    end else if (inc_i) begin
      idx_q <= idx_q + 8'h01;
    end
  end

  assign idx_o = idx_q;
  assign tc_o  = (idx_q == 8'(Len - 1));

endmodule

// File: rtl/oam_dma_controller.sv
// OAM DMA engine: a write to the DMA register copies page XX00-XX9F into OAM, one byte per cycle,
// with the write of byte k-1 overlapped with the read of byte k.
module oam_dma_controller
  import oam_dma_controller_pkg::*;
#(
  parameter logic [15:0] DmaAddr  = DmaRegAddr,
  parameter logic [15:0] OamAddr  = OamBase,
  parameter int unsigned Len      = XferLen,
  parameter int unsigned StartDly = StartDelay
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  oam_dma_controller_if.master        bus,
  inout  wire  [7:0]                  ioreg_data_io
);

  dma_state_e state_q;
  logic [7:0] src_hi_q;
  logic [7:0] delay_q;
  logic [7:0] hold_q;
  logic [7:0] idx;
  logic       tc;
  logic       trigger;
  logic       read_hit;

  assign trigger  = !bus.ioreg_we_l && (bus.ioreg_addr == DmaAddr);
  assign read_hit = !bus.ioreg_re_l && (bus.ioreg_addr == DmaAddr);

  assign ioreg_data_io = read_hit ? src_hi_q : 8'hzz;

  // Index stays frozen through DRAIN so the final write address can be decoded from it.
  oam_dma_controller_byte_counter #(
    .Len (Len)
  ) u_byte_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (trigger || (state_q == StIdle) || (state_q == StStart)),
    .inc_i  ((state_q == StXfer) && !tc),
    .idx_o  (idx),
    .tc_o   (tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      src_hi_q <= 8'h00;
      delay_q  <= 8'h00;
      hold_q   <= 8'h00;
    end else begin
      if (state_q == StXfer) begin
        hold_q <= bus.rdma_data;
      end
      if (trigger) begin
        src_hi_q <= ioreg_data_io;
        delay_q  <= 8'(StartDly);
        state_q  <= StStart;
      end else begin
        unique case (state_q)
          StIdle:  state_q <= StIdle;
          StStart: begin
            if (delay_q <= 8'd1) begin
              state_q <= StXfer;
            end else begin
              delay_q <= delay_q - 8'd1;
            end
          end
          StXfer:  if (tc) state_q <= StDrain;
          StDrain: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // A trigger in the same cycle as a pending write discards that write.
  always_comb begin
    bus.rdma_re_l = 1'b1;
    bus.rdma_addr = 16'h0000;
    bus.wdma_we_l = 1'b1;
    bus.wdma_addr = 16'h0000;
    bus.wdma_data = 8'h00;
    if (state_q == StXfer) begin
      bus.rdma_re_l = 1'b0;
      bus.rdma_addr = {src_eff(src_hi_q), idx};
    end
    if (!trigger && (((state_q == StXfer) && (idx != 8'h00)) || (state_q == StDrain))) begin
      bus.wdma_we_l = 1'b0;
      bus.wdma_addr = OamAddr + {8'h00, idx} - {15'd0, state_q == StXfer};
      bus.wdma_data = hold_q;
    end
  end

  assign bus.dma_active = (state_q != StIdle);

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench: memory model, table-driven and random full transfers, plus retrigger,
// trigger-during-drain and mid-transfer reset sequences.
module tb_oam_dma_controller;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  oam_dma_controller_if bus ();
  wire  [7:0] ioreg_data;
  logic [7:0] drv = 8'h00;
  logic       drv_en = 1'b0;
  assign ioreg_data = drv_en ? drv : 8'hzz;

  oam_dma_controller dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .bus           (bus),
    .ioreg_data_io (ioreg_data)
  );

  logic [7:0] mem [0:65535];
  assign bus.rdma_data = mem[bus.rdma_addr];
  always @(posedge clk) if (!bus.wdma_we_l) mem[bus.wdma_addr] <= bus.wdma_data;

  int errors = 0;
  int checks = 0;

  // Transfer statistics gathered by the negedge monitor.
  logic [7:0]  exp_eff = 8'h00;
  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, rd_err = 0, pipe_err = 0;
  logic [15:0] first_raddr = 16'h0, last_waddr = 16'h0;
  logic        prev_rd = 1'b0;
  logic [7:0]  prev_rdata = 8'h00;

  always @(negedge clk) begin
    if (!bus.wdma_we_l) begin
      wr_cnt++;
      last_waddr = bus.wdma_addr;
      if (!prev_rd || bus.wdma_data !== prev_rdata) pipe_err++;
      if (!bus.rdma_re_l) both_cnt++;
    end
    if (!bus.rdma_re_l) begin
      if (rd_cnt == 0) first_raddr = bus.rdma_addr;
      if (bus.rdma_addr !== {exp_eff, 8'(rd_cnt)}) rd_err++;
      rd_cnt++;
    end
    prev_rd    = !bus.rdma_re_l;
    prev_rdata = bus.rdma_data;
  end

  function automatic logic [7:0] model_eff(input logic [7:0] v);
    int x;
    x = int'(v);
    if (x >= 224) x = x - 32;
    return 8'(x);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_stats(input logic [7:0] src);
    exp_eff  = model_eff(src);
    rd_cnt   = 0;
    wr_cnt   = 0;
    both_cnt = 0;
    rd_err   = 0;
    pipe_err = 0;
    prev_rd  = 1'b0;
  endtask

  task automatic start_write(input logic [7:0] v);
    bus.ioreg_addr = 16'hFF46;
    drv            = v;
    drv_en         = 1'b1;
    bus.ioreg_we_l = 1'b0;
  endtask

  task automatic end_write(input logic [7:0] v);
    @(posedge clk);
    #1;
    bus.ioreg_we_l = 1'b1;
    drv_en         = 1'b0;
    bus.ioreg_addr = 16'h0000;
    reset_stats(v);
  endtask

  task automatic do_write(input logic [7:0] v);
    @(negedge clk);
    start_write(v);
    end_write(v);
  endtask

  task automatic io_read(output logic [7:0] v);
    @(negedge clk);
    bus.ioreg_addr = 16'hFF46;
    bus.ioreg_re_l = 1'b0;
    #1 v = ioreg_data;
    bus.ioreg_re_l = 1'b1;
    bus.ioreg_addr = 16'h0000;
  endtask

  // Counts ACTIVE cycles until it drops; reads FF46 mid-transfer to show it is harmless.
  task automatic wait_done(input logic [7:0] src, output int act);
    act = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.dma_active) break;
      act++;
      if (act == 80) begin
        bus.ioreg_addr = 16'hFF46;
        bus.ioreg_re_l = 1'b0;
        #1 check("readback_mid", ioreg_data, src);
        bus.ioreg_re_l = 1'b1;
        bus.ioreg_addr = 16'h0000;
      end
    end
    if (act >= 400) check("active_timeout", act, 162);
  endtask

  task automatic check_oam(input string name, input logic [7:0] src);
    int bad = 0;
    int base = int'(model_eff(src)) * 256;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== mem[base + i]) bad++;
    check(name, bad, 0);
  endtask

  task automatic scramble_oam();
    for (int i = 0; i < 160; i++) mem[16'hFE00 + i] = 8'($urandom);
  endtask

  task automatic run_full(input logic [7:0] src, input logic [7:0] eff);
    int act;
    logic [7:0] rb;
    scramble_oam();
    do_write(src);
    check("active_rise", bus.dma_active, 1);
    wait_done(src, act);
    check("active_len", act, 162);
    check("first_raddr", first_raddr, {eff, 8'h00});
    check("last_waddr", last_waddr, 16'hFE9F);
    check("read_seq", rd_err, 0);
    check("pipe_data", pipe_err, 0);
    check("re_we_overlap", both_cnt, 159);
    check("write_count", wr_cnt, 160);
    check_oam("oam_copy", src);
    io_read(rb);
    check("readback", rb, src);
  endtask

  typedef struct {
    logic [7:0] src;
    logic [7:0] eff;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int act;
    logic [7:0] snap [160];
    int bad_lo, bad_hi;

    vecs[0] = '{8'hC1, 8'hC1};
    vecs[1] = '{8'hE3, 8'hC3};
    vecs[2] = '{8'h80, 8'h80};
    vecs[3] = '{8'hDF, 8'hDF};
    vecs[4] = '{8'hE0, 8'hC0};
    vecs[5] = '{8'hFF, 8'hDF};

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    bus.ioreg_addr = 16'h0000;
    bus.ioreg_we_l = 1'b1;
    bus.ioreg_re_l = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", {bus.rdma_re_l, bus.wdma_we_l}, 2'b11);
    check("rst_active", bus.dma_active, 0);
    check("rst_raddr", bus.rdma_addr, 0);
    check("rst_waddr", bus.wdma_addr, 0);
    check("rst_wdata", bus.wdma_data, 0);
    @(negedge clk) rst_ni = 1'b1;
    io_read(rb);
    check("rst_readback", rb, 8'h00);

    for (int v = 0; v < 6; v++) run_full(vecs[v].src, vecs[v].eff);

    for (int r = 0; r < 4; r++) begin
      logic [7:0] s;
      s = 8'($urandom_range(0, 255));
      run_full(s, model_eff(s));
    end

    // Retrigger with D0 while on XFER byte 50
    scramble_oam();
    do_write(8'hC1);
    repeat (51) @(posedge clk);
    @(negedge clk);
    check("retrig_pos", bus.rdma_addr, 16'hC132);
    start_write(8'hD0);
    #1 check("retrig_wr_suppressed", bus.wdma_we_l, 1);
    end_write(8'hD0);
    check("retrig_start_strobes", {bus.rdma_re_l, bus.wdma_we_l}, 2'b11);
    check("retrig_active", bus.dma_active, 1);
    wait_done(8'hD0, act);
    check("retrig_len", act, 162);
    check("retrig_first_raddr", first_raddr, 16'hD000);
    check("retrig_pipe", pipe_err, 0);
    check_oam("retrig_oam", 8'hD0);

    // Trigger on the DRAIN cycle
    do_write(8'hC4);
    repeat (161) @(posedge clk);
    @(negedge clk);
    check("drain_strobes", {bus.rdma_re_l, bus.wdma_we_l}, 2'b10);
    check("drain_waddr", bus.wdma_addr, 16'hFE9F);
    start_write(8'hC6);
    #1 check("drain_wr_suppressed", bus.wdma_we_l, 1);
    end_write(8'hC6);
    check("drain_restart", {bus.dma_active, bus.rdma_re_l, bus.wdma_we_l}, 3'b111);
    wait_done(8'hC6, act);
    check("drain_retrig_len", act, 162);
    check_oam("drain_retrig_oam", 8'hC6);

    // Reset at XFER byte 80
    for (int i = 0; i < 160; i++) snap[i] = mem[16'hFE00 + i];
    do_write(8'hC5);
    repeat (81) @(posedge clk);
    @(negedge clk);
    check("rst_mid_pos", bus.rdma_addr, 16'hC550);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_strobes", {bus.rdma_re_l, bus.wdma_we_l}, 2'b11);
    check("rst_mid_active", bus.dma_active, 0);
    wr_cnt = 0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_writes", wr_cnt, 0);
    bad_lo = 0;
    bad_hi = 0;
    for (int i = 0; i < 79; i++) if (mem[16'hFE00 + i] !== mem[16'hC500 + i]) bad_lo++;
    for (int i = 80; i < 160; i++) if (mem[16'hFE00 + i] !== snap[i]) bad_hi++;
    check("rst_mid_oam_written", bad_lo, 0);
    check("rst_mid_oam_untouched", bad_hi, 0);
    rst_ni = 1'b1;
    io_read(rb);
    check("rst_mid_readback", rb, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
